// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display driver.
// Segment patterns are seg[6:0] = {a,b,c,d,e,f,g}, active-high.
package seg_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;

  // Width of a digit index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Datapath-facing bus of the display driver.
//   en, value, load, hex_mode, lz_suppress : control and data from the datapath
//   seg, an, frame_done                    : pin drive and frame strobe
// slave = display driver side, master = datapath/bench side.
interface seg_display_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      en;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      load;
  logic                      hex_mode;
  logic                      lz_suppress;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport slave (
    input  en, value, load, hex_mode, lz_suppress,
    output seg, an, frame_done
  );

  modport master (
    output en, value, load, hex_mode, lz_suppress,
    input  seg, an, frame_done
  );
endinterface

// File: rtl/seg_digit_decoder.sv
// Combinational nibble-to-segment decoder.
//   nibble   : digit value 0..15
//   hex_mode : 1 = show A..F, 0 = BCD (10..15 blank)
//   blank    : force the digit dark
//   seg      : active-high segment pattern {a..g}
module seg_digit_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
        4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
        4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
        4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
        4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
        4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering.
//   clk, rst_n : system clock, async active-low reset
//   bus.en          : 1 = scan, 0 = dark and scan held at digit 0
//   bus.value/load  : nibble vector and capture strobe
//   bus.hex_mode    : hex vs BCD decode
//   bus.lz_suppress : blank leading zero digits
//   bus.seg/an      : registered pin drive (inverted when ACTIVE_LOW)
//   bus.frame_done  : one-cycle pulse on the last cycle of each frame
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_display_mux_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
  localparam int unsigned CNT_W = idx_width(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      pending;
  logic                  pend_flag;
  logic [VAL_W-1:0]      active;
  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  assign tick           = bus.en && (cnt == LAST_CNT);
  assign boundary       = tick && (idx == LAST_IDX);
  assign bus.frame_done = boundary;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;

  // Refresh counter and digit index; held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!bus.en) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Double buffer: a load at the boundary lands in pending after the
  // previous pending value has moved to active (later assignment wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else if (!bus.en) begin
      if (bus.load) begin
        active    <= bus.value;
        pending   <= bus.value;
        pend_flag <= 1'b0;
      end
    end else begin
      if (boundary && pend_flag) begin
        active    <= pending;
        pend_flag <= 1'b0;
      end
      if (bus.load) begin
        pending   <= bus.value;
        pend_flag <= 1'b1;
      end
    end
  end

  // Digit i (i >= 1) is blanked when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (active[4*i +: 4] == 4'h0);
      blank_mask[i] = bus.lz_suppress && upper_zero;
    end
  end

  // Select the nibble, blank flag and anode for the current digit.
  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = active[4*i +: 4];
        cur_blank    = blank_mask[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  seg_digit_decoder u_dec (
    .nibble   (cur_nib),
    .hex_mode (bus.hex_mode),
    .blank    (cur_blank),
    .seg      (dec_seg)
  );

  // Pin registers; polarity applied here only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else if (!bus.en) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= ACTIVE_LOW ? ~dec_seg : dec_seg;
      an_q  <= ACTIVE_LOW ? ~an_onehot : an_onehot;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: one active-high and one active-low
// instance, both with 4 digits and a 4-cycle refresh period.
module tb_seg_display_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg_display_mux_if #(.NUM_DIGITS(4)) bus0 ();
  seg_display_mux_if #(.NUM_DIGITS(4)) bus1 ();

  seg_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  seg_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks one 16-cycle frame on bus0 starting at the negedge where digit 0
  // is first lit; optionally issues up to two loads and sets the decode
  // controls for the following frame on the last cycle.
  task automatic run_frame(input string tag,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input int lc1, input logic [15:0] lv1,
                           input int lc2, input logic [15:0] lv2,
                           input logic nhex, input logic nlz);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    for (int c = 0; c < 16; c++) begin
      exp_an = 4'b0001 << (c / 4);
      check($sformatf("%s c%0d an", tag, c), 32'(bus0.an), 32'(exp_an));
      check($sformatf("%s c%0d seg", tag, c), 32'(bus0.seg), 32'(exp_seg[c / 4]));
      check($sformatf("%s c%0d frame_done", tag, c), 32'(bus0.frame_done), 32'(c == 14));
      bus0.load = 1'b0;
      if (c == lc1) begin
        bus0.value = lv1;
        bus0.load  = 1'b1;
      end
      if (c == lc2) begin
        bus0.value = lv2;
        bus0.load  = 1'b1;
      end
      if (c == 15) begin
        bus0.hex_mode    = nhex;
        bus0.lz_suppress = nlz;
      end
      @(negedge clk);
    end
    bus0.load = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus0.en = 1'b0; bus0.load = 1'b0; bus0.value = '0; bus0.hex_mode = 1'b0; bus0.lz_suppress = 1'b1;
    bus1.en = 1'b0; bus1.load = 1'b0; bus1.value = '0; bus1.hex_mode = 1'b0; bus1.lz_suppress = 1'b0;

    repeat (2) @(negedge clk);
    check("rst an0", 32'(bus0.an), 32'h0);
    check("rst seg0", 32'(bus0.seg), 32'h00);
    check("rst frame_done0", 32'(bus0.frame_done), 32'h0);
    check("rst an1", 32'(bus1.an), 32'hF);
    check("rst seg1", 32'(bus1.seg), 32'h7F);

    bus0.en = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);

    run_frame("f0_default", 7'h7E, 7'h00, 7'h00, 7'h00, 5, 16'h1234, -1, 16'h0, 1'b1, 1'b1);
    run_frame("f1_bcd1234", 7'h33, 7'h79, 7'h6D, 7'h30, 3, 16'hABCD, -1, 16'h0, 1'b1, 1'b1);
    run_frame("f2_hexABCD", 7'h3D, 7'h4E, 7'h1F, 7'h77, -1, 16'h0, -1, 16'h0, 1'b0, 1'b1);
    run_frame("f3_bcdABCD", 7'h00, 7'h00, 7'h00, 7'h00, 6, 16'h0050, -1, 16'h0, 1'b0, 1'b1);
    run_frame("f4_lz_on", 7'h7E, 7'h5B, 7'h00, 7'h00, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
    run_frame("f5_lz_off", 7'h7E, 7'h5B, 7'h7E, 7'h7E, 2, 16'h0007, 14, 16'h0009, 1'b0, 1'b0);
    run_frame("f6_collide_x", 7'h70, 7'h7E, 7'h7E, 7'h7E, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
    run_frame("f7_collide_y", 7'h7B, 7'h7E, 7'h7E, 7'h7E, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);

    // Disable mid-scan, load directly while dark, then re-enable.
    repeat (5) @(negedge clk);
    bus0.en = 1'b0;
    @(negedge clk);
    check("dis an0", 32'(bus0.an), 32'h0);
    check("dis seg0", 32'(bus0.seg), 32'h00);
    check("dis frame_done0", 32'(bus0.frame_done), 32'h0);
    bus0.value = 16'h0003;
    bus0.load  = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    check("dis_load an0", 32'(bus0.an), 32'h0);
    check("dis_load seg0", 32'(bus0.seg), 32'h00);
    bus0.en = 1'b1;
    @(negedge clk);
    run_frame("f8_reenable", 7'h79, 7'h7E, 7'h7E, 7'h7E, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
    run_frame("f9_steady", 7'h79, 7'h7E, 7'h7E, 7'h7E, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);

    // Active-low instance.
    bus1.en = 1'b1;
    @(negedge clk);
    check("al d0 an1", 32'(bus1.an), 32'hE);
    check("al d0 seg1", 32'(bus1.seg), 32'h01);
    repeat (4) @(negedge clk);
    check("al d1 an1", 32'(bus1.an), 32'hD);
    check("al d1 seg1", 32'(bus1.seg), 32'h01);

    #2 rst_n = 1'b0;
    #1;
    check("async an1", 32'(bus1.an), 32'hF);
    check("async seg1", 32'(bus1.seg), 32'h7F);
    check("async an0", 32'(bus0.an), 32'h0);
    check("async seg0", 32'(bus0.seg), 32'h00);
    check("async frame_done0", 32'(bus0.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("al restart an1", 32'(bus1.an), 32'hE);
    check("al restart seg1", 32'(bus1.seg), 32'h01);
    check("restart an0", 32'(bus0.an), 32'h1);
    check("restart seg0", 32'(bus0.seg), 32'h7E);

    repeat (5) @(negedge clk);
    check("al mid an1", 32'(bus1.an), 32'hD);
    bus1.en = 1'b0;
    @(negedge clk);
    check("al dis an1", 32'(bus1.an), 32'hF);
    check("al dis seg1", 32'(bus1.seg), 32'h7F);
    bus1.en = 1'b1;
    @(negedge clk);
    check("al reen an1", 32'(bus1.an), 32'hE);
    check("al reen seg1", 32'(bus1.seg), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Time-multiplexed driver for a parametrised bank of common-anode/common-cathode seven-segment digits. It accepts a packed vector of nibbles and scans one digit per refresh period. Each nibble is decoded in BCD or hexadecimal mode, with optional leading-zero suppression. New values are double-buffered and applied only at frame boundaries, so a display update never tears mid-frame. It sits between the datapath (counters, measurement results) and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles each digit is lit (>= 2)
- ACTIVE_LOW, 0, 1 inverts both `seg` and `an` at the pins
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- en  in  1  1 = scanning, 0 = display dark and scan held
- value  in  4*NUM_DIGITS  digit i = value[4i+3:4i]; digit 0 is least significant
- load  in  1  capture `value` (one-cycle strobe)
- hex_mode  in  1  1 = decode 0–F, 0 = BCD (10–15 blank)
- lz_suppress  in  1  blank leading zero digits
- seg  out  7  segments, seg[6]=a … seg[0]=g, active-high before ACTIVE_LOW
- an  out  NUM_DIGITS  one-hot digit enable, an[i] lights digit i
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- **Registers**
  - `cnt`: refresh counter, 0..REFRESH_DIV-1.
  - `idx`: digit index, 0..NUM_DIGITS-1, width max(1, clog2(NUM_DIGITS)).
  - `pending`: value register plus a `pend_flag`.
  - `active`: display register.
- **Load path**
  - With en=1: load writes `value` into `pending` and sets `pend_flag`. A later load overwrites `pending`.
  - With en=0: load writes `value` directly into both `active` and `pending`, and clears `pend_flag`.
- **Scan and frame boundary**
  - `tick` = (cnt == REFRESH_DIV-1). On tick, `cnt` returns to 0 and `idx` increments, wrapping from NUM_DIGITS-1 to 0.
  - Frame boundary = tick while idx == NUM_DIGITS-1. At the boundary:
    - if `pend_flag` is set, then active <= pending and `pend_flag` clears;
    - frame_done = 1 for that cycle.
  - Load coinciding with the boundary: the pre-existing `pending` is transferred to `active`. The newly loaded value stays in `pending` with `pend_flag` set, and is applied at the next boundary.
- **Decode, BCD mode**
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex values of seg[6:0]).
  - Nibbles 10–15 decode to blank (00).
- **Decode, hex mode**
  - 0–9 as in BCD mode, plus A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- **Leading-zero suppression**
  - Digit i (i ≥ 1) is blank when lz_suppress=1 and every nibble j ≥ i of `active` is zero.
  - Digit 0 is never suppressed.
  - A blanked digit still has its `an` bit asserted, with seg=00.
- **en=0**
  - `cnt` and `idx` are held at 0, frame_done=0, and `an` and `seg` are driven inactive.
  - On re-enable, scanning restarts at digit 0.
- **ACTIVE_LOW=1**: bitwise inversion applied only at the output registers.

## Timing
- Reset (asynchronous, immediate, including mid-frame) sets:
  - cnt=0, idx=0, active=0, pending=0, pend_flag=0, frame_done=0;
  - seg and an inactive: 0 for ACTIVE_LOW=0, all ones otherwise.
- `seg` and `an` are registered from `idx` and `active`, so they lag an `idx` change by 1 cycle.
- First cycle after reset release with en=1: digit 0 is lit.
- Each digit is lit for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS×REFRESH_DIV cycles.
- Load-to-visible latency: the next frame boundary, plus 1 cycle.
- `frame_done` is combinationally derived from registered state and is high for exactly 1 cycle per frame.

## Structure
- Package `seg_display_pkg` contains:
  - the 16 segment-pattern constants and SEG_BLANK (7'h00);
  - the index width helper.
- Sub-module `seg_digit_decoder` is purely combinational: inputs nibble, hex_mode, blank; output seg[6:0].
- Everything else (counter, scan, double buffer, suppression mask, output registers) lives in `seg_display_mux`.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4 unless noted.
- **Reset and default scan**: assert rst_n=0 → an=0000, seg=00. Release with en=1, lz_suppress=1, no load → an=0001/seg=7E; digits 1–3 lit but seg=00; frame_done pulses every 16 cycles.
- **Buffered load**: load 16'h1234 (BCD) mid-frame → current frame unchanged. Next frame gives:
  - an=0001 seg=33
  - an=0010 seg=79
  - an=0100 seg=6D
  - an=1000 seg=30
- **Decode modes**: load 16'hABCD.
  - hex_mode=1 → digit0..3 = 3D, 4E, 1F, 77.
  - hex_mode=0 → all digits seg=00.
- **Leading-zero suppression**:
  - 16'h0050 → digits 3 and 2 blank, digit1=5B, digit0=7E.
  - lz_suppress=0 → digits 3 and 2 show 7E.
- **Boundary collision**: load X, then load Y on the frame_done cycle → X is displayed for the next frame, Y for the frame after.
- **ACTIVE_LOW=1 and disable**:
  - Reset gives an=1111, seg=7F.
  - Async reset or en=0 mid-scan turns all outputs inactive immediately; re-enable restarts at digit 0.
